// File: rtl/conv_kxk_stream_if.sv
// conv_kxk_stream_if: frame control, pixel stream, weight load and result
// signals of conv_kxk_stream; the engine sits on the slave modport.
interface conv_kxk_stream_if #(
  parameter int DW = 16
);
  logic          start;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          w_load;
  logic [DW-1:0] w_data;
  logic          relu_en;
  logic [DW-1:0] map_out;
  logic          save;
  logic          ready;
  logic          done;

  modport master (
    output start, pix_in, pix_valid, w_load, w_data, relu_en,
    input  map_out, save, ready, done
  );

  modport slave (
    input  start, pix_in, pix_valid, w_load, w_data, relu_en,
    output map_out, save, ready, done
  );
endinterface

// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream: streaming KxK convolution over a raster pixel stream with
// runtime weights/bias, 3-stage MAC pipeline, round/saturate/ReLU output.
module conv_kxk_stream #(
  parameter int DW    = 16,
  parameter int FRAC  = 12,
  parameter int K     = 9,
  parameter int IMG_W = 96,
  parameter int IMG_H = 96
) (
  input  logic             clk_in,
  input  logic             rst_n,
  conv_kxk_stream_if.slave bus
);
  localparam int KK  = K * K;
  localparam int PW  = 2 * DW;
  localparam int ACC = 2 * DW + $clog2(KK) + 1;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int IW  = $clog2(KK + 1);

  localparam logic signed [ACC-1:0] RND  = {{(ACC-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC-1:0] MAXV = {{(ACC-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC-1:0] MINV = {{(ACC-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic                  ready, done, accept, qual, last_px;
  logic                  start_q;
  logic [IW-1:0]         widx_q;
  logic signed [DW-1:0]  coef_q [KK];
  logic signed [DW-1:0]  bias_q;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic [DW-1:0]         line_q [K-1][IMG_W];
  logic signed [DW-1:0]  tap    [K];
  logic signed [DW-1:0]  win_q  [K][K];
  logic signed [DW-1:0]  win_d  [K][K];
  logic signed [PW-1:0]  prod_q [KK];
  logic signed [ACC-1:0] rsum_d [K];
  logic signed [ACC-1:0] rsum_q [K];
  logic                  v1_q, v2_q, save_q, l1_q, l2_q, l3_q;
  logic signed [ACC-1:0] total, shifted;
  logic [DW-1:0]         res_d, map_q;

  assign ready   = (state_q != S_DONE);
  assign accept  = bus.start && ready && bus.pix_valid;
  assign qual    = (col_q >= CW'(K - 1)) && (row_q >= RW'(K - 1));
  assign last_px = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
  assign done    = (state_q == S_RUN) && save_q && l3_q;

  assign bus.map_out = map_q;
  assign bus.save    = save_q;
  assign bus.ready   = ready;
  assign bus.done    = done;

  always_comb begin
    state_d = state_q;
    if (!bus.start) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   if (done) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Weight index restarts with every new frame; loads during a frame are dropped.
  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      start_q <= 1'b0;
      widx_q  <= '0;
      bias_q  <= '0;
      for (int unsigned i = 0; i < KK; i++) coef_q[i] <= '0;
    end else begin
      start_q <= bus.start;
      if (bus.start && !start_q) begin
        widx_q <= '0;
      end else if (!bus.start && bus.w_load) begin
        if (widx_q == IW'(KK)) begin
          bias_q <= bus.w_data;
          widx_q <= '0;
        end else begin
          for (int unsigned i = 0; i < KK; i++)
            if (widx_q == IW'(i)) coef_q[i] <= bus.w_data;
          widx_q <= widx_q + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!bus.start) begin
        col_q <= '0;
        row_q <= '0;
      end else if (accept) begin
        if (col_q == CW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  // line_q[K-2] holds the previous line, line_q[0] the oldest one.
  always_comb begin
    for (int unsigned r = 0; r + 1 < K; r++) tap[r] = line_q[r][col_q];
    tap[K-1] = bus.pix_in;
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      for (int unsigned l = 0; l + 2 < K; l++) line_q[l][col_q] <= line_q[l+1][col_q];
      line_q[K-2][col_q] <= bus.pix_in;
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c + 1 < K; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = tap[r];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    win_q <= win_d;
  end

  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      rsum_d[r] = '0;
      for (int unsigned c = 0; c < K; c++)
        rsum_d[r] = rsum_d[r] + ACC'(prod_q[r*K+c]);
    end
  end

  always_comb begin
    total = RND + (ACC'(bias_q) <<< FRAC);
    for (int unsigned r = 0; r < K; r++) total = total + rsum_q[r];
    shifted = total >>> FRAC;
    if (shifted > MAXV)      res_d = MAXV[DW-1:0];
    else if (shifted < MINV) res_d = MINV[DW-1:0];
    else                     res_d = shifted[DW-1:0];
    if (bus.relu_en && res_d[DW-1]) res_d = '0;
  end

  // Products are taken from the post-shift window so stage 1 lands on the
  // accepting edge, keeping pixel-to-save latency at 3 cycles.
  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < KK; i++) prod_q[i] <= '0;
      for (int unsigned r = 0; r < K; r++) rsum_q[r] <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      save_q <= 1'b0;
      l1_q   <= 1'b0;
      l2_q   <= 1'b0;
      l3_q   <= 1'b0;
      map_q  <= '0;
    end else begin
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++)
          prod_q[r*K+c] <= PW'(coef_q[r*K+c]) * PW'(win_d[r][c]);
      rsum_q <= rsum_d;
      if (!bus.start) begin
        v1_q   <= 1'b0;
        v2_q   <= 1'b0;
        save_q <= 1'b0;
        l1_q   <= 1'b0;
        l2_q   <= 1'b0;
        l3_q   <= 1'b0;
      end else begin
        v1_q   <= accept && qual;
        l1_q   <= accept && qual && last_px;
        v2_q   <= v1_q;
        l2_q   <= l1_q;
        save_q <= v2_q;
        l3_q   <= l2_q;
        if (v2_q) map_q <= res_d;
      end
    end
  end
endmodule

// File: tb/tb_conv_kxk_stream.sv
// Self-checking bench for conv_kxk_stream (K=3, 8x6 frames) against a plain
// arithmetic convolution model with randomized data and pixel gaps.
module tb_conv_kxk_stream;
  localparam int DW   = 16;
  localparam int FRAC = 12;
  localparam int K    = 3;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;

  typedef struct {
    logic [DW-1:0] val;
    int            due;
    bit            is_last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  shortint img [H][W];
  shortint wts [K*K];
  shortint bias_m;
  bit      relu_m;

  conv_kxk_stream_if #(.DW(DW)) bus ();

  conv_kxk_stream #(
    .DW(DW), .FRAC(FRAC), .K(K), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk_in (clk),
    .rst_n  (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Output for the window whose top-left pixel is img[r][c].
  function automatic logic [DW-1:0] ref_px(int r, int c);
    longint acc = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc += longint'(wts[i*K+j]) * longint'(img[r+i][c+j]);
    acc = acc + longint'(bias_m) * (longint'(1) << FRAC) + (longint'(1) << (FRAC - 1));
    acc = acc >>> FRAC;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu_m && acc < 0) acc = 0;
    return acc[DW-1:0];
  endfunction

  function automatic void fill_img(int mode, shortint v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = shortint'(16 * r + c);
          1:       img[r][c] = v;
          default: img[r][c] = shortint'($urandom);
        endcase
  endfunction

  function automatic void set_center(shortint center, shortint b);
    for (int i = 0; i < K*K; i++) wts[i] = 0;
    wts[(K*K)/2] = center;
    bias_m = b;
  endfunction

  task automatic load_weights();
    for (int i = 0; i <= K*K; i++) begin
      @(negedge clk);
      bus.start  = 1'b0;
      bus.w_load = 1'b1;
      bus.w_data = (i < K*K) ? wts[i] : bias_m;
    end
    @(negedge clk);
    bus.w_load = 1'b0;
  endtask

  task automatic run_frame(input bit sparse, input int abort_after, input bit wl_noise, input string tag);
    exp_t q[$];
    exp_t e;
    int   p = 0, got = 0, budget = 0;
    bit   fin = 0, seen_done = 0, hit, exp_done, v;
    bus.relu_en = relu_m;
    while (!fin) begin
      @(negedge clk);
      budget++;
      hit = (q.size() > 0) && (q[0].due == cyc);
      exp_done = 0;
      if (seen_done) begin
        n_checks++;
        if (bus.ready !== 1'b0 || bus.save !== 1'b0) begin
          n_fail++;
          $display("FAIL %s ready_after_done ready=%b save=%b required 0/0", tag, bus.ready, bus.save);
        end
        fin = 1;
      end else begin
        n_checks++;
        if (bus.save !== hit) begin
          n_fail++;
          $display("FAIL %s save_timing cyc=%0d save=%b required %b", tag, cyc, bus.save, hit);
        end
        if (hit) begin
          e = q.pop_front();
          got++;
          exp_done = e.is_last;
          n_checks++;
          if (bus.map_out !== e.val) begin
            n_fail++;
            $display("FAIL %s map_out result=%0d got %h required %h", tag, got, bus.map_out, e.val);
          end
        end
        n_checks++;
        if (bus.done !== exp_done) begin
          n_fail++;
          $display("FAIL %s done cyc=%0d got %b required %b", tag, cyc, bus.done, exp_done);
        end
        if (exp_done) seen_done = 1;
        if (abort_after > 0 && got == abort_after) begin
          bus.start = 0; bus.pix_valid = 0; bus.w_load = 0;
          for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.save !== 1'b0 || bus.done !== 1'b0 || bus.ready !== 1'b1) begin
              n_fail++;
              $display("FAIL %s abort_quiet save=%b done=%b ready=%b required 0/0/1",
                       tag, bus.save, bus.done, bus.ready);
            end
          end
          fin = 1;
        end
        if (!fin && budget > 400) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s timeout results=%0d required %0d", tag, got, q.size() + got);
          fin = 1;
        end
      end
      if (!fin) begin
        bus.start  = 1'b1;
        bus.w_load = wl_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.w_data = DW'($urandom);
        v = 0;
        if (p < NPIX) v = sparse ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.pix_valid = v;
        if (v) begin
          bus.pix_in = img[p / W][p % W];
          if (p / W >= K - 1 && p % W >= K - 1)
            q.push_back('{val: ref_px(p / W - (K - 1), p % W - (K - 1)), due: cyc + 3,
                          is_last: (p == NPIX - 1)});
          p++;
        end
      end
    end
    bus.start = 0; bus.pix_valid = 0; bus.w_load = 0;
    @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_idle got %b required 1", tag, bus.ready);
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.pix_valid = 0; bus.w_load = 0; bus.relu_en = 0;
    bus.pix_in = '0; bus.w_data = '0;
    rst = 1;
    #12;
    n_checks++;
    if (bus.map_out !== '0) begin n_fail++; $display("FAIL reset map_out got %h required 0000", bus.map_out); end
    n_checks++;
    if (bus.save !== 1'b0) begin n_fail++; $display("FAIL reset save got %b required 0", bus.save); end
    n_checks++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset ready got %b required 1", bus.ready); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b required 0", bus.done); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_identity();
    relu_m = 0;
    set_center(16'sh1000, 0);
    load_weights();
    fill_img(0, 0);
    run_frame(0, 0, 0, "identity");
  endtask

  task automatic test_rounding();
    relu_m = 0;
    set_center(16'sh0800, 0);
    load_weights();
    fill_img(1, 3);
    run_frame(0, 0, 0, "round_p3");
    fill_img(1, -3);
    run_frame(0, 0, 0, "round_m3");
    fill_img(1, 1);
    run_frame(0, 0, 0, "round_p1");
  endtask

  task automatic test_saturation_relu();
    for (int i = 0; i < K*K; i++) wts[i] = 16'sh7FFF;
    bias_m = 0;
    relu_m = 0;
    load_weights();
    fill_img(1, 16'sh7FFF);
    run_frame(0, 0, 0, "sat_pos");
    fill_img(1, -32768);
    run_frame(0, 0, 0, "sat_neg");
    relu_m = 1;
    run_frame(0, 0, 0, "sat_relu");
    relu_m = 0;
  endtask

  task automatic test_bias_sparse();
    relu_m = 0;
    set_center(16'sh1000, 5);
    load_weights();
    fill_img(0, 0);
    run_frame(1, 0, 0, "bias_sparse");
  endtask

  task automatic test_abort_reload();
    relu_m = 0;
    set_center(16'sh1000, 0);
    load_weights();
    fill_img(0, 0);
    run_frame(0, 20, 1, "abort");
    run_frame(0, 0, 0, "restart");
  endtask

  task automatic test_random();
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < K*K; i++) wts[i] = shortint'($urandom);
      bias_m = shortint'($urandom);
      relu_m = 1'($urandom_range(0, 1));
      load_weights();
      fill_img(2, 0);
      run_frame(1, 0, 0, "random");
    end
    relu_m = 0;
  endtask

  task automatic test_async_reset();
    relu_m = 0;
    set_center(16'sh1000, 0);
    load_weights();
    fill_img(0, 0);
    bus.relu_en = 0;
    for (int p = 0; p < 30; p++) begin
      @(negedge clk);
      bus.start = 1; bus.pix_valid = 1; bus.pix_in = img[p / W][p % W];
    end
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    n_checks++;
    if (bus.map_out !== '0) begin n_fail++; $display("FAIL async_reset map_out got %h required 0000", bus.map_out); end
    n_checks++;
    if (bus.save !== 1'b0) begin n_fail++; $display("FAIL async_reset save got %b required 0", bus.save); end
    n_checks++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL async_reset ready got %b required 1", bus.ready); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL async_reset done got %b required 0", bus.done); end
    @(negedge clk);
    bus.start = 0; bus.pix_valid = 0;
    rst = 0;
    for (int i = 0; i < K*K; i++) wts[i] = 0;
    bias_m = 0;
    run_frame(0, 0, 0, "post_reset_cleared");
    set_center(16'sh1000, 0);
    load_weights();
    run_frame(0, 0, 0, "post_reset_reload");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rounding();
    test_saturation_relu();
    test_bias_sparse();
    test_abort_reload();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_kxk_stream.md
# conv_kxk_stream

Parametrised streaming K×K convolution engine for one input and one output feature map. It succeeds the fixed 9×9, 96-wide, hard-coded-weight convolution layers. It takes a raster-order pixel stream with a valid qualifier, holds a (K−1)-line buffer plus a K×K window, and multiplies the window by runtime-loaded weights. It adds a loaded bias, rounds, saturates, optionally applies ReLU, and emits only valid-region ("no padding") results with a `save` strobe. It sits between the pixel source / previous layer and the pooling or next convolution stage.

## Interface
- `DW`, 16: pixel, weight, bias and output width, signed two's complement.
- `FRAC`, 12: fractional bits of weights. Q(DW−FRAC).FRAC.
- `K`, 9: kernel side, 2..15.
- `IMG_W`, 96: input line length in pixels, K..1023.
- `IMG_H`, 96: input lines per frame, K..1023.
- `clk_in`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-high reset (name kept per codebase; 1 = reset).
- `start`  in  1  frame enable. High for the whole frame. Low clears counters and pipeline, not weights.
- `pix_in`  in  DW  input pixel.
- `pix_valid`  in  1  `pix_in` is accepted this cycle.
- `w_load`  in  1  weight/bias write strobe. Honoured only while `start`=0.
- `w_data`  in  DW  weight or bias word.
- `relu_en`  in  1  clamp negative results to 0. Static during a frame.
- `map_out`  out  DW  result pixel.
- `save`  out  1  `map_out` valid this cycle.
- `ready`  out  1  engine can accept or is accepting a frame.
- `done`  out  1  one-cycle pulse, frame complete.

## Operation
- **Weight load**
  - Index counter `widx` runs 0..K·K.
  - Each `w_load` cycle writes `w_data` to coefficient[widx], then increments `widx`.
  - At index K·K the word is the bias; after it `widx` wraps to 0.
  - `widx` is cleared by reset and by the rising edge of `start`.
  - Coefficient[r·K+c]: r=0 is the oldest (top) window row, c=0 the oldest (left) column.
  - Weights and bias reset to 0.
- **Window and line buffer**
  - On each accepted pixel (`start` & `ready` & `pix_valid`), the line buffer and window shift by one.
  - The column counter `col` (0..IMG_W−1) and row counter `row` (0..IMG_H−1) advance, `col` wrapping into `row`.
  - Nothing moves without `pix_valid`; gaps of any length are allowed.
- **Result qualification**
  - A result is computed for an accepted pixel with `col`≥K−1 and `row`≥K−1.
  - That gives (IMG_W−K+1)·(IMG_H−K+1) results per frame, in raster order.
- **Arithmetic**
  - Products are full 2·DW signed.
  - Accumulator width is ACC = 2·DW + clog2(K·K) + 1, with no intermediate truncation.
  - Bias is sign-extended and added as bias<<FRAC.
  - Rounding is half-up: (acc + 2^(FRAC−1)) >>> FRAC.
  - The result saturates to [−2^(DW−1), 2^(DW−1)−1].
  - If `relu_en`, negative results become 0.
- **States**
  - IDLE: `ready`=1. Goes to RUN when `start`=1.
  - RUN: `ready`=1, accepts pixels. Goes to DONE the cycle the last result leaves the pipeline; `done` pulses in that cycle.
  - DONE: `ready`=0, pixels ignored. Goes to IDLE when `start`=0.
- **Aborts and collisions**
  - `start` low in any state returns to IDLE next cycle, flushes the pipeline (no further `save`) and zeroes the counters.
  - `w_load` while `start`=1 is ignored.

## Timing
- Reset values: `map_out`=0, `save`=0, `ready`=1, `done`=0. State IDLE, counters 0, coefficients 0.
- Latency is fixed at 3 cycles from a qualifying accepted pixel to its `save`:
  - stage 1 registers the products;
  - stage 2 registers the K row sums;
  - stage 3 registers the total, bias, rounding, saturation and ReLU into `map_out`.
- Pipeline stages advance every cycle regardless of `pix_valid`, so `save` gaps mirror input gaps.
- `save` is high for exactly one cycle per result.
- `done` asserts in the same cycle as the final `save`. `ready` falls the following cycle.
- Back-to-back frames: drop `start` for ≥1 cycle, then raise it again; the first pixel is accepted in the cycle `start` is first seen high.
- Reset asserted mid-frame takes effect immediately and asynchronously: outputs go to reset values and the loaded weights are lost.

## Test plan
- **Identity kernel.** K=3, IMG_W=8, IMG_H=6. Center weight 0x1000, others 0, bias 0. Input pixel = 16·row+col, streamed continuously.
  -> 24 `save` pulses, values 16·(r+1)+(c+1) for r 0..3, c 0..5.
  -> First `save` 3 cycles after pixel (2,2). `done` on the 24th pulse.
- **Rounding.** Same setup, single center weight 0x0800 (0.5).
  -> Constant pixel 3 gives 2; pixel −3 gives −1; pixel 1 gives 1.
- **Saturation and ReLU.**
  - All nine weights 0x7FFF, all pixels 0x7FFF -> 0x7FFF.
  - Pixels 0x8000 with `relu_en`=0 -> 0x8000.
  - Pixels 0x8000 with `relu_en`=1 -> 0x0000.
- **Bias and sparse input.** Identity kernel, bias 5. `pix_valid` toggled 1-0-0-1 pseudo-randomly.
  -> Same 24 values as the identity test, each +5, in order.
  -> Each `save` exactly 3 cycles after its pixel.
- **Abort and reload.**
  - Drop `start` after 20 results -> no further `save`, no `done`, `ready`=1.
  - `w_load` pulsed during RUN -> weights unchanged.
  - Restarting with a full frame -> all 24 correct results.
- **Async reset.** Assert `rst_n`=1 between clock edges mid-frame.
  -> Outputs 0/0/1/0 immediately.
  -> After reload, a fresh frame gives correct results.
